// File: rtl/run_host_ctrl.sv
// Host-side sequencer for the core's req/done run: preload, core reset, req, wait, drain.
// Optional HOST_CHECKSUM_EN: XOR of drained result bytes on checksum; otherwise tied to zero.
module run_host_ctrl #(
  parameter int AW        = 8,
  parameter int NLOAD     = 64,
  parameter int LOAD_BASE = 0,
  parameter int NREAD     = 64,
  parameter int READ_BASE = 64,
  parameter int TMO       = 4095
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          in_valid,
  input  logic [7:0]    in_data,
  output logic          in_ready,
  output logic          core_reset,
  output logic          core_req,
  input  logic          core_done,
  output logic          mem_sel,
  output logic          mem_wr_en,
  output logic [AW-1:0] mem_addr,
  output logic [7:0]    mem_wdata,
  input  logic [7:0]    mem_rdata,
  output logic          out_valid,
  output logic [7:0]    out_data,
  input  logic          out_ready,
  output logic          busy,
  output logic          timeout,
  output logic [15:0]   cycles,
  output logic [7:0]    checksum
);
  localparam int NMAX = (NLOAD > NREAD) ? NLOAD : NREAD;
  localparam int IW   = $clog2(NMAX + 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RST, S_RUN, S_DRAIN} state_t;

  state_t        state, state_nx;
  logic [IW-1:0] idx;
  logic          rst_ph;
  logic [15:0]   cyc_inc;
  logic          load_xfer, drain_xfer, last_load, last_read, done_hit, tmo_hit;

  assign cyc_inc    = (cycles == 16'hFFFF) ? cycles : cycles + 16'd1;
  assign load_xfer  = (state == S_LOAD) && in_valid;
  assign drain_xfer = (state == S_DRAIN) && out_ready;
  assign last_load  = (idx == IW'(NLOAD - 1));
  assign last_read  = (idx == IW'(NREAD - 1));
  // cycles==0 marks the req cycle, where a stale done must not end the run
  assign done_hit   = (state == S_RUN) && (cycles != 16'd0) && core_done;
  assign tmo_hit    = (state == S_RUN) && !done_hit && (cyc_inc == 16'(TMO));

  always_comb begin
    state_nx   = state;
    in_ready   = 1'b0;
    core_reset = 1'b0;
    core_req   = 1'b0;
    mem_sel    = 1'b0;
    mem_wr_en  = 1'b0;
    mem_addr   = '0;
    mem_wdata  = 8'h00;
    out_valid  = 1'b0;
    out_data   = 8'h00;
    busy       = (state != S_IDLE);
    case (state)
      S_IDLE:  if (start) state_nx = S_LOAD;
      S_LOAD: begin
        in_ready  = 1'b1;
        mem_sel   = 1'b1;
        mem_wr_en = in_valid;
        mem_addr  = AW'(LOAD_BASE) + AW'(idx);
        mem_wdata = in_data;
        if (load_xfer && last_load) state_nx = S_RST;
      end
      S_RST: begin
        core_reset = 1'b1;
        mem_sel    = 1'b1;
        if (rst_ph) state_nx = S_RUN;
      end
      S_RUN: begin
        core_req = (cycles == 16'd0);
        if (done_hit || tmo_hit) state_nx = S_DRAIN;
      end
      S_DRAIN: begin
        mem_sel   = 1'b1;
        mem_addr  = AW'(READ_BASE) + AW'(idx);
        out_valid = 1'b1;
        out_data  = mem_rdata;
        if (drain_xfer && last_read) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      idx     <= '0;
      rst_ph  <= 1'b0;
      timeout <= 1'b0;
      cycles  <= 16'd0;
    end else begin
      state <= state_nx;
      case (state)
        S_IDLE: if (start) begin
          idx     <= '0;
          rst_ph  <= 1'b0;
          timeout <= 1'b0;
          cycles  <= 16'd0;
        end
        S_LOAD:  if (load_xfer) idx <= last_load ? '0 : idx + IW'(1);
        S_RST:   rst_ph <= ~rst_ph;
        S_RUN: begin
          cycles <= cyc_inc;
          if (tmo_hit) timeout <= 1'b1;
        end
        S_DRAIN: if (drain_xfer) idx <= idx + IW'(1);
        default: ;
      endcase
    end
  end

`ifdef HOST_CHECKSUM_EN
  logic [7:0] csum;
  always_ff @(posedge clk) begin
    if (reset)                       csum <= 8'h00;
    else if (state == S_IDLE && start) csum <= 8'h00;
    else if (drain_xfer)             csum <= csum ^ mem_rdata;
  end
  assign checksum = csum;
`else
  assign checksum = 8'h00;
`endif
endmodule

// File: tb/tb_run_host_ctrl.sv
// Scoreboarded bench for run_host_ctrl: expected writes/results queued by stimulus, checked by a monitor.
module tb_run_host_ctrl;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0, in_valid = 1'b0, core_done = 1'b0, out_ready = 1'b1;
  logic [7:0] in_data = 8'h00;
  logic in_ready, core_reset, core_req, mem_sel, mem_wr_en, out_valid, busy, timeout;
  logic [7:0] mem_addr, mem_wdata, mem_rdata, out_data, checksum;
  logic [15:0] cycles;
  logic [7:0] mem [256];

  int nchk = 0, nfail = 0, rst_seen = 0, req_seen = 0;
  logic [15:0] exp_wr[$];
  logic [7:0]  exp_out[$];
  logic [7:0]  ops [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
`ifdef HOST_CHECKSUM_EN
  localparam logic [7:0] CSUM = 8'hFF;
`else
  localparam logic [7:0] CSUM = 8'h00;
`endif

  run_host_ctrl #(.AW(8), .NLOAD(4), .LOAD_BASE(0), .NREAD(2), .READ_BASE(64), .TMO(20)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .core_reset(core_reset), .core_req(core_req), .core_done(core_done),
    .mem_sel(mem_sel), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .busy(busy), .timeout(timeout), .cycles(cycles), .checksum(checksum));

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (reset) begin
      mem[64] <= 8'hA5;
      mem[65] <= 8'h5A;
    end else if (mem_wr_en) mem[mem_addr] <= mem_wdata;
  end
  assign mem_rdata = mem[mem_addr];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // monitor: pops the scoreboard whenever the DUT writes memory or hands out a result
  initial forever begin
    @(negedge clk);
    if (!reset) begin
      if (core_reset) rst_seen++;
      if (core_req) req_seen++;
      if (mem_wr_en) begin
        if (exp_wr.size() == 0) chk("unexpected_wr", {mem_addr, mem_wdata}, 16'h0);
        else chk("mem_wr", {mem_addr, mem_wdata}, exp_wr.pop_front());
      end
      if (out_valid && out_ready) begin
        if (exp_out.size() == 0) chk("unexpected_out", {24'h0, out_data}, 32'h1FF);
        else chk("out_data", {24'h0, out_data}, {24'h0, exp_out.pop_front()});
      end
    end
  end

  task automatic load_and_req(output bit ok);
    int k;
    start = 1'b1; tick(); start = 1'b0;
    chk("start_busy", busy, 1);
    chk("start_clears_timeout", timeout, 0);
    chk("start_clears_cycles", cycles, 0);
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = ops[i];
      exp_wr.push_back({8'(i), ops[i]});
      tick();
    end
    in_valid = 1'b0;
    k = 0;
    while (!core_req && k < 10) begin tick(); k++; end
    ok = core_req;
    if (!ok) chk("req_wait_expired", 0, 1);
    else chk("run_mem_sel", mem_sel, 0);
  endtask

  // done_at: RUN cycle (req cycle = 1) in which done is raised; 0 = never
  task automatic run(input int done_at, input bit stale, input bit stall, input bit poke);
    int r0, q0, cur, k;
    bit ok;
    r0 = rst_seen; q0 = req_seen;
    exp_out.push_back(8'hA5); exp_out.push_back(8'h5A);
    if (stale) core_done = 1'b1;
    load_and_req(ok);
    cur = 1;
    if (stale || poke) begin
      if (poke) begin start = 1'b1; in_valid = 1'b1; end
      tick(); core_done = 1'b0; start = 1'b0; in_valid = 1'b0; cur = 2;
    end
    if (done_at > 0) begin
      repeat (done_at - cur) tick();
      core_done = 1'b1; tick(); core_done = 1'b0;
      chk("done_cycles", cycles, 32'(done_at));
      chk("done_no_timeout", timeout, 0);
    end else begin
      k = 0;
      while (!out_valid && k < 40) begin tick(); k++; end
      chk("tmo_reached_drain", out_valid, 1);
      chk("tmo_flag", timeout, 1);
      chk("tmo_cycles", cycles, 20);
    end
    chk("drain_mem_sel", mem_sel, 1);
    if (stall) begin
      tick(); out_ready = 1'b0;
      for (int i = 0; i < 7; i++) begin
        chk("stall_addr", mem_addr, 8'd65);
        chk("stall_data", out_data, 8'h5A);
        tick();
      end
      out_ready = 1'b1;
    end
    k = 0;
    while (busy && k < 20) begin tick(); k++; end
    chk("idle_after_drain", busy, 0);
    chk("drained_all", exp_out.size(), 0);
    chk("wrote_all", exp_wr.size(), 0);
    chk("core_reset_cycles", rst_seen - r0, 2);
    chk("core_req_pulses", req_seen - q0, 1);
    chk("checksum", checksum, CSUM);
    tick();
    chk("no_queued_start", busy, 0);
  endtask

  initial begin
    bit ok;
    repeat (3) tick();
    reset = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_outs", {in_ready, core_reset, core_req, mem_sel, mem_wr_en, out_valid, timeout}, 0);
    chk("rst_vals", {mem_addr, out_data, cycles, checksum}, 0);
    run(10, 0, 0, 0);
    for (int i = 0; i < 4; i++) chk("mem_content", mem[i], ops[i]);
    run(0, 0, 0, 0);
    run(5, 1, 0, 0);
    chk("timeout_cleared", timeout, 0);
    run(3, 0, 1, 0);
    load_and_req(ok);
    repeat (3) tick();
    reset = 1'b1; tick();
    chk("abort_outs", {busy, in_ready, core_reset, core_req, mem_sel, mem_wr_en, out_valid, timeout}, 0);
    chk("abort_vals", {mem_addr, out_data, cycles, checksum}, 0);
    reset = 1'b0; tick();
    run(7, 0, 0, 1);
    $display("[TB] %0d tests run, %0d failed", nchk, nfail);
    $finish;
  end
endmodule
